// File: rtl/bram_boot_loader.sv
// Boot-time loader: streams host words into the data BRAM, then the instruction BRAM,
// holding the core stalled until both images are in place.
module bram_boot_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-2:0] d_count_i,
  input  logic [ADDR_W-2:0] i_count_i,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] d_w_addr_o,
  output logic [DATA_W-1:0] d_w_dat_o,
  output logic              d_w_enb_o,
  output logic [ADDR_W-1:0] i_w_addr_o,
  output logic [DATA_W-1:0] i_w_dat_o,
  output logic              i_w_enb_o,
  output logic              d_bram_init_done_o,
  output logic              pc_stall_o,
  output logic              i_r_enb_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int CNT_W = ADDR_W - 1;
  localparam logic [CNT_W-1:0] CAP = CNT_W'(2 ** IDX_W);

  typedef enum logic [1:0] {IDLE, LOAD_D, LOAD_I, RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  d_cnt_q, i_cnt_q;
  logic              s_ready_q, busy_q, pc_stall_q, i_r_enb_q, done_q, err_q;
  logic              d_w_enb_q, i_w_enb_q;
  logic [ADDR_W-1:0] d_w_addr_q, i_w_addr_q;
  logic [DATA_W-1:0] d_w_dat_q, i_w_dat_q;

  logic              accept, last_word, can_start, counts_ok, start_ok, start_bad;
  logic [CNT_W-1:0]  cur_cnt;

  always_comb begin
    accept    = s_valid_i && s_ready_q;
    cur_cnt   = (state_q == LOAD_D) ? d_cnt_q : i_cnt_q;
    last_word = ({1'b0, idx_q} == (cur_cnt - CNT_W'(1)));
    can_start = (state_q == IDLE) || (state_q == RUN);
    counts_ok = (d_count_i <= CAP) && (i_count_i <= CAP);
    start_ok  = start_i && can_start && counts_ok;
    start_bad = start_i && can_start && !counts_ok;
    state_d   = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (start_ok) begin
          if (d_count_i != '0)      state_d = LOAD_D;
          else if (i_count_i != '0) state_d = LOAD_I;
          else                      state_d = RUN;
        end
      end
      LOAD_D: if (accept && last_word) state_d = (i_cnt_q != '0) ? LOAD_I : RUN;
      LOAD_I: if (accept && last_word) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so LOAD_D -> LOAD_I needs no bubble.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      d_cnt_q    <= '0;
      i_cnt_q    <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      pc_stall_q <= 1'b1;
      i_r_enb_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      d_w_enb_q  <= 1'b0;
      i_w_enb_q  <= 1'b0;
      d_w_addr_q <= '0;
      i_w_addr_q <= '0;
      d_w_dat_q  <= '0;
      i_w_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d == LOAD_D) || (state_d == LOAD_I);
      busy_q     <= (state_d == LOAD_D) || (state_d == LOAD_I);
      pc_stall_q <= (state_d != RUN);
      i_r_enb_q  <= (state_d == RUN);
      done_q     <= (state_d == RUN);
      err_q      <= start_bad;
      d_w_enb_q  <= accept && (state_q == LOAD_D);
      i_w_enb_q  <= accept && (state_q == LOAD_I);
      if (start_ok) begin
        idx_q   <= '0;
        d_cnt_q <= d_count_i;
        i_cnt_q <= i_count_i;
      end else if (accept) begin
        idx_q <= last_word ? '0 : idx_q + IDX_W'(1);
      end
      if (accept && (state_q == LOAD_D)) begin
        d_w_addr_q <= {idx_q, 2'b00};
        d_w_dat_q  <= s_data_i;
      end
      if (accept && (state_q == LOAD_I)) begin
        i_w_addr_q <= {idx_q, 2'b00};
        i_w_dat_q  <= s_data_i;
      end
    end
  end

  assign s_ready_o          = s_ready_q;
  assign busy_o             = busy_q;
  assign pc_stall_o         = pc_stall_q;
  assign i_r_enb_o          = i_r_enb_q;
  assign d_bram_init_done_o = done_q;
  assign err_o              = err_q;
  assign d_w_enb_o          = d_w_enb_q;
  assign i_w_enb_o          = i_w_enb_q;
  assign d_w_addr_o         = d_w_addr_q;
  assign i_w_addr_o         = i_w_addr_q;
  assign d_w_dat_o          = d_w_dat_q;
  assign i_w_dat_o          = i_w_dat_q;

endmodule

// File: tb/tb_bram_boot_loader.sv
// Bench for bram_boot_loader: start-decision table plus randomized streams scored
// against where each word must land (word k -> data 4k, or instr 4(k-d_count)).
module tb_bram_boot_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [8:0]  d_count_i = '0;
  logic [8:0]  i_count_i = '0;
  logic        s_valid_i = 1'b0;
  logic [31:0] s_data_i = '0;
  logic        s_ready_o;
  logic [9:0]  d_w_addr_o, i_w_addr_o;
  logic [31:0] d_w_dat_o, i_w_dat_o;
  logic        d_w_enb_o, i_w_enb_o;
  logic        d_bram_init_done_o, pc_stall_o, i_r_enb_o, busy_o, err_o;

  int vectors = 0;
  int miscompares = 0;

  bram_boot_loader #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .d_count_i(d_count_i), .i_count_i(i_count_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .d_w_addr_o(d_w_addr_o), .d_w_dat_o(d_w_dat_o), .d_w_enb_o(d_w_enb_o),
    .i_w_addr_o(i_w_addr_o), .i_w_dat_o(i_w_dat_o), .i_w_enb_o(i_w_enb_o),
    .d_bram_init_done_o(d_bram_init_done_o), .pc_stall_o(pc_stall_o),
    .i_r_enb_o(i_r_enb_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int   dc;
    int   ic;
    logic err;
    logic busy;
    logic rdy;
    logic stall;
    logic run;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetDut(input bit doCheck);
    @(negedge clk_i);
    rst_ni = 1'b0;
    start_i = 1'b0;
    s_valid_i = 1'b0;
    #1;
    if (doCheck) begin
      checkOutput("rst_pc_stall", 32'(pc_stall_o), 32'd1);
      checkOutput("rst_i_r_enb", 32'(i_r_enb_o), 32'd0);
      checkOutput("rst_done", 32'(d_bram_init_done_o), 32'd0);
      checkOutput("rst_enb", {30'd0, d_w_enb_o, i_w_enb_o}, 32'd0);
      checkOutput("rst_s_ready", 32'(s_ready_o), 32'd0);
      checkOutput("rst_busy_err", {30'd0, busy_o, err_o}, 32'd0);
      checkOutput("rst_addr", {12'd0, d_w_addr_o, i_w_addr_o}, 32'd0);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  // Streams d_count+i_count words; abortAt >= 0 returns after that many writes.
  task automatic applyStimulus(input int dc, input int ic, input int mode, input int abortAt);
    logic [31:0] words[$];
    int total, sent, seen, pend, cyc, budget, k;
    logic sv;
    total = dc + ic;
    sent = 0; seen = 0; pend = -1; cyc = 0;
    budget = 4 * total + 20;
    for (int w = 0; w < total; w++) words.push_back($urandom);
    start_i = 1'b1;
    d_count_i = 9'(dc);
    i_count_i = 9'(ic);
    s_valid_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    if (total > 0) begin
      checkOutput("load_pc_stall", 32'(pc_stall_o), 32'd1);
      checkOutput("load_run_flags", {30'd0, i_r_enb_o, d_bram_init_done_o}, 32'd0);
      checkOutput("load_busy", 32'(busy_o), 32'd1);
    end
    while (seen < total && cyc < budget) begin
      if (pend >= 0) begin
        k = pend;
        if (k < dc) begin
          checkOutput("d_w_enb", {30'd0, d_w_enb_o, i_w_enb_o}, 32'd2);
          checkOutput("d_w_addr", 32'(d_w_addr_o), 32'(4 * k));
          checkOutput("d_w_dat", d_w_dat_o, words[k]);
        end else begin
          checkOutput("i_w_enb", {30'd0, d_w_enb_o, i_w_enb_o}, 32'd1);
          checkOutput("i_w_addr", 32'(i_w_addr_o), 32'(4 * (k - dc)));
          checkOutput("i_w_dat", i_w_dat_o, words[k]);
        end
        seen++;
      end else begin
        checkOutput("idle_wr", {30'd0, d_w_enb_o, i_w_enb_o}, 32'd0);
      end
      checkOutput("load_err", 32'(err_o), 32'd0);
      if (seen == total) break;
      if (abortAt >= 0 && seen == abortAt) begin
        s_valid_i = 1'b0;
        return;
      end
      if (sent < total) begin
        checkOutput("load_s_ready", 32'(s_ready_o), 32'd1);
        checkOutput("load_stall", 32'(pc_stall_o), 32'd1);
      end
      case (mode)
        0:       sv = 1'b1;
        1:       sv = cyc[0] == 1'b0;
        default: sv = $urandom_range(0, 1) == 1;
      endcase
      sv = sv && (sent < total);
      start_i = (mode == 2) && (sent < total) && ($urandom_range(0, 7) == 0);
      d_count_i = 9'd1;
      i_count_i = 9'd1;
      pend = (sv && s_ready_o) ? sent : -1;
      s_valid_i = sv;
      s_data_i = sv ? words[sent] : $urandom;
      if (pend >= 0) sent++;
      @(negedge clk_i);
      cyc++;
    end
    s_valid_i = 1'b0;
    start_i = 1'b0;
    if (seen < total) checkOutput("timeout", 32'(seen), 32'(total));
    if (total > 0) @(negedge clk_i);
    checkOutput("run_pc_stall", 32'(pc_stall_o), 32'd0);
    checkOutput("run_flags", {29'd0, i_r_enb_o, d_bram_init_done_o, busy_o}, 32'd6);
    checkOutput("run_s_ready", 32'(s_ready_o), 32'd0);
    for (int c = 0; c < 3; c++) begin
      s_valid_i = 1'b1;
      s_data_i = $urandom;
      @(negedge clk_i);
      checkOutput("run_ignore_wr", {30'd0, d_w_enb_o, i_w_enb_o}, 32'd0);
      checkOutput("run_ignore_rdy", 32'(s_ready_o), 32'd0);
    end
    s_valid_i = 1'b0;
  endtask

  initial begin
    vec_t tbl[8];
    tbl[0] = '{2,   7,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{0,   1,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{0,   0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{257, 1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1,   300, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{256, 256, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{511, 511, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{0,   257, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    resetDut(1'b1);
    for (int t = 0; t < 8; t++) begin
      resetDut(1'b0);
      start_i = 1'b1;
      d_count_i = 9'(tbl[t].dc);
      i_count_i = 9'(tbl[t].ic);
      @(negedge clk_i);
      start_i = 1'b0;
      checkOutput($sformatf("tbl%0d_err", t), 32'(err_o), 32'(tbl[t].err));
      checkOutput($sformatf("tbl%0d_busy", t), 32'(busy_o), 32'(tbl[t].busy));
      checkOutput($sformatf("tbl%0d_rdy", t), 32'(s_ready_o), 32'(tbl[t].rdy));
      checkOutput($sformatf("tbl%0d_stall", t), 32'(pc_stall_o), 32'(tbl[t].stall));
      checkOutput($sformatf("tbl%0d_run", t), {30'd0, i_r_enb_o, d_bram_init_done_o},
                  tbl[t].run ? 32'd3 : 32'd0);
      checkOutput($sformatf("tbl%0d_wr", t), {30'd0, d_w_enb_o, i_w_enb_o}, 32'd0);
      @(negedge clk_i);
      checkOutput($sformatf("tbl%0d_err_pulse", t), 32'(err_o), 32'd0);
    end

    resetDut(1'b1);
    applyStimulus(2, 7, 0, -1);
    applyStimulus(2, 7, 1, -1);
    applyStimulus(0, 1, 0, -1);
    resetDut(1'b0);
    applyStimulus(0, 0, 0, -1);
    applyStimulus(3, 0, 2, -1);

    // Rejected reload from RUN keeps the core running.
    start_i = 1'b1;
    d_count_i = 9'd257;
    i_count_i = 9'd0;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("run_err", 32'(err_o), 32'd1);
    checkOutput("run_err_stall", 32'(pc_stall_o), 32'd0);
    @(negedge clk_i);
    checkOutput("run_err_pulse", 32'(err_o), 32'd0);
    checkOutput("run_err_state", {30'd0, busy_o, i_r_enb_o}, 32'd1);

    applyStimulus(0, 256, 0, -1);
    for (int r = 0; r < 6; r++)
      applyStimulus($urandom_range(0, 20), $urandom_range(1, 20), 2, -1);

    applyStimulus(5, 2, 0, 3);
    resetDut(1'b1);
    applyStimulus(5, 2, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
